// File: rtl/seq_detector_param_if.sv
// Serial detector bus: input bit stream with qualifier and clear,
// plus the registered match pulse, match counter and progress state.
interface seq_detector_param_if #(
  parameter int CNT_W = 8,
  parameter int PW    = 3
);
  logic             x_in;
  logic             x_valid;
  logic             clear;
  logic             y_out;
  logic [CNT_W-1:0] match_count;
  logic [PW-1:0]    progress;

  // Bit source / controller side
  modport master (
    output x_in, x_valid, clear,
    input  y_out, match_count, progress
  );

  // Detector side
  modport slave (
    input  x_in, x_valid, clear,
    output y_out, match_count, progress
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector. Progress is the length of the
// longest pattern prefix that is a suffix of the accepted bits; the
// KMP-style transitions are resolved at elaboration into a constant
// lookup table indexed by {progress, x_in}.
module seq_detector_param #(
  parameter int                PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                OVERLAP = 1'b1,
  parameter int                CNT_W   = 8,
  parameter int                PW      = $clog2(PAT_LEN + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);

  // Each table entry: [5] = match, [4:0] = next progress (overlap applied)
  localparam int ENT_W = 6;
  localparam int TBL_W = PAT_LEN * 2 * ENT_W;

  // Longest proper prefix of the whole pattern that is also its suffix.
  function automatic int fail_full();
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < PAT_LEN; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (PATTERN[k-1-i] != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // Transition table: for state p and bit b, the longest prefix that is a
  // suffix of (prefix_p followed by b). Reaching PAT_LEN means a match.
  function automatic logic [TBL_W-1:0] build_table();
    logic [TBL_W-1:0] t;
    int               best;
    int               j;
    int               nx;
    logic             ok;
    logic             s_bit;
    logic             hit;
    t = '0;
    for (int p = 0; p < PAT_LEN; p++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        for (int k = 1; k <= p + 1; k++) begin
          ok = 1'b1;
          for (int i = 0; i < k; i++) begin
            j = p + 1 - k + i;
            s_bit = (j < p) ? PATTERN[PAT_LEN-1-j] : (b == 1);
            if (s_bit != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
          end
          if (ok) best = k;
        end
        hit = (best == PAT_LEN);
        if (hit) nx = OVERLAP ? fail_full() : 0;
        else     nx = best;
        t[(p*2+b)*ENT_W +: ENT_W] = {hit, 5'(nx)};
      end
    end
    return t;
  endfunction

  localparam logic [TBL_W-1:0] TABLE = build_table();

  logic [PW-1:0]    progress_q, progress_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW:0]      idx_s;
  logic [ENT_W-1:0] entry_s;

  assign idx_s = {progress_q, bus.x_in};

  // Look up the transition for the current progress and incoming bit
  always_comb begin
    entry_s = TABLE[int'(idx_s)*ENT_W +: ENT_W];
  end

  // Next-state: clear beats a qualified sample; counter saturates
  always_comb begin
    progress_d = progress_q;
    y_d        = 1'b0;
    count_d    = count_q;
    if (bus.clear) begin
      progress_d = '0;
      count_d    = '0;
    end else if (bus.x_valid) begin
      progress_d = PW'(entry_s[4:0]);
      if (entry_s[5]) begin
        y_d = 1'b1;
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          count_d = count_q;
        end
      end else begin
        y_d = 1'b0;
      end
    end else begin
      progress_d = progress_q;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      progress_q <= '0;
      y_q        <= 1'b0;
      count_q    <= '0;
    end else begin
      progress_q <= progress_d;
      y_q        <= y_d;
      count_q    <= count_d;
    end
  end

  assign bus.progress    = progress_q;
  assign bus.y_out       = y_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param. Three instances share one
// stimulus stream: A overlapping, B non-overlapping, C non-overlapping
// with a 2-bit saturating counter.
module tb_seq_detector_param;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  seq_detector_param_if #(.CNT_W(8), .PW(3)) ifa ();
  seq_detector_param_if #(.CNT_W(8), .PW(3)) ifb ();
  seq_detector_param_if #(.CNT_W(2), .PW(3)) ifc ();

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .bus(ifc));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic x, input logic v, input logic c);
    ifa.x_in = x; ifa.x_valid = v; ifa.clear = c;
    ifb.x_in = x; ifb.x_valid = v; ifb.clear = c;
    ifc.x_in = x; ifc.x_valid = v; ifc.clear = c;
  endtask

  // Apply inputs, let one rising edge happen, sample just after it
  task automatic step(input logic x, input logic v, input logic c);
    set_in(x, v, c);
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  logic s1_x  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  int   s1_pa [7] = '{1, 2, 3, 1, 2, 3, 1};
  int   s1_ya [7] = '{0, 0, 0, 1, 0, 0, 1};
  int   s1_pb [7] = '{1, 2, 3, 0, 0, 1, 1};
  int   s1_yb [7] = '{0, 0, 0, 1, 0, 0, 0};

  logic s3_x  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int   s3_p  [8] = '{1, 2, 3, 2, 3, 2, 3, 1};
  int   s3_y  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  logic s4_x  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic s4_v  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int   s4_p  [8] = '{1, 1, 2, 2, 3, 3, 1, 1};
  int   s4_y  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

  int   s5_cnt [5] = '{1, 2, 3, 3, 3};
  logic pat    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_prog", 32'(ifa.progress), 32'd0);
    check("rst_y", 32'(ifa.y_out), 32'd0);
    check("rst_cnt", 32'(ifa.match_count), 32'd0);
    reset = 1'b0;

    // Overlapping vs non-overlapping on 1011011
    for (int i = 0; i < 7; i++) begin
      step(s1_x[i], 1'b1, 1'b0);
      check($sformatf("t1_prog_a%0d", i), 32'(ifa.progress), 32'(s1_pa[i]));
      check($sformatf("t1_y_a%0d", i), 32'(ifa.y_out), 32'(s1_ya[i]));
      check($sformatf("t2_prog_b%0d", i), 32'(ifb.progress), 32'(s1_pb[i]));
      check($sformatf("t2_y_b%0d", i), 32'(ifb.y_out), 32'(s1_yb[i]));
    end
    check("t1_cnt_a", 32'(ifa.match_count), 32'd2);
    check("t2_cnt_b", 32'(ifb.match_count), 32'd1);

    // Failure-function fallback on 10101011
    do_clear();
    check("clr_cnt_a", 32'(ifa.match_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(s3_x[i], 1'b1, 1'b0);
      check($sformatf("t3_prog%0d", i), 32'(ifa.progress), 32'(s3_p[i]));
      check($sformatf("t3_y%0d", i), 32'(ifa.y_out), 32'(s3_y[i]));
    end
    check("t3_cnt", 32'(ifa.match_count), 32'd1);

    // Qualifier gaps with x_in toggling
    do_clear();
    for (int i = 0; i < 8; i++) begin
      step(s4_x[i], s4_v[i], 1'b0);
      check($sformatf("t4_prog%0d", i), 32'(ifa.progress), 32'(s4_p[i]));
      check($sformatf("t4_y%0d", i), 32'(ifa.y_out), 32'(s4_y[i]));
    end
    check("t4_cnt", 32'(ifa.match_count), 32'd1);

    // Saturation on the 2-bit counter, then clear with a valid bit
    do_clear();
    for (int m = 0; m < 5; m++) begin
      for (int b = 0; b < 4; b++) step(pat[b], 1'b1, 1'b0);
      check($sformatf("t5_y%0d", m), 32'(ifc.y_out), 32'd1);
      check($sformatf("t5_cnt%0d", m), 32'(ifc.match_count), 32'(s5_cnt[m]));
    end
    check("t5_cnt_b", 32'(ifb.match_count), 32'd5);
    for (int b = 0; b < 3; b++) step(pat[b], 1'b1, 1'b0);
    check("t5_pre_prog", 32'(ifc.progress), 32'd3);
    step(1'b1, 1'b1, 1'b1);
    check("t5_clr_cnt", 32'(ifc.match_count), 32'd0);
    check("t5_clr_prog", 32'(ifc.progress), 32'd0);
    check("t5_clr_y", 32'(ifc.y_out), 32'd0);

    // Asynchronous reset mid-pattern
    step(1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) step(pat[b], 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t6_pre_prog", 32'(ifa.progress), 32'd3);
    check("t6_pre_cnt", 32'(ifa.match_count), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_prog", 32'(ifa.progress), 32'd0);
    check("t6_async_cnt", 32'(ifa.match_count), 32'd0);
    check("t6_async_y", 32'(ifa.y_out), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("t6_hold_prog", 32'(ifa.progress), 32'd0);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check("t6_rel_prog", 32'(ifa.progress), 32'd1);
    check("t6_rel_y", 32'(ifa.y_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern-detector FSM. Generalises the fixed 4-state detector to a configurable pattern, pattern length, overlap mode, input qualifier and saturating match counter.
- Sits between a serial bit source and control logic. It flags each occurrence of PATTERN in the qualified input stream.
- Internally a prefix-match (KMP-style) state machine with PAT_LEN+1 progress states.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 1..16.
- PATTERN, 4'b1011, pattern to detect; PATTERN[PAT_LEN-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = progress restarts from 0 after a match.
- CNT_W, 8, width of the match counter.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- x_in  input  1  serial data bit.
- x_valid  input  1  sample qualifier; x_in is consumed only when x_valid=1.
- clear  input  1  synchronous clear of progress, y_out and match_count.
- y_out  output  1  registered one-cycle match pulse.
- match_count  output  CNT_W  saturating count of matches since reset/clear.
- progress  output  PW  current matched-prefix length; PW = $clog2(PAT_LEN+1).

Behaviour:
- Reset (asynchronous, active-high): progress=0, y_out=0, match_count=0 immediately; held while reset=1.
- progress state p in 0..PAT_LEN-1 = length of the longest pattern prefix that is a suffix of the accepted bits.
- Expected next bit at progress p is PATTERN[PAT_LEN-1-p].
- Per rising edge, with reset=0, priority is clear > x_valid:
  - clear=1: progress=0, y_out=0, match_count=0; x_in ignored.
  - x_valid=0: progress holds; y_out=0; match_count holds.
  - x_valid=1, bit equals expected bit: p' = p+1.
  - x_valid=1, bit mismatches: fall back through the failure function. p' = longest k<=p such that the prefix of length k equals the suffix of (accepted bits + x_in). This can be 0.
- Match when p' == PAT_LEN:
  - y_out=1 for exactly the following cycle.
  - match_count increments, saturating at 2^CNT_W-1.
  - progress is never PAT_LEN: it loads failure(PAT_LEN) if OVERLAP=1, else 0.
- Latency: y_out is high in the cycle immediately after the edge that samples the final pattern bit. Back-to-back matches give y_out high in consecutive qualified cycles.
- Failure table: computed at elaboration from PATTERN/PAT_LEN, or as a combinational loop. No run-time configuration.
- Counter: wrap-around is forbidden; it stays at all-ones once saturated.
- Reset mid-pattern: partial progress is discarded; detection restarts from an empty history.

Test Plan:
1. PATTERN=1011, OVERLAP=1, x_valid=1, stream 1,0,1,1,0,1,1 -> y_out high after samples 4 and 7; match_count=2; progress after sample 4 = 1.
2. Same stream, OVERLAP=0 -> y_out high after sample 4 only; match_count=1; progress sequence 1,2,3,0,0,1,1.
3. OVERLAP=1, stream 1,0,1,0,1,0,1,1 -> progress 1,2,3,2,3,2,3,then 1; single y_out pulse after sample 8; match_count=1.
4. Stream 1,0,1,1 with x_valid=0 cycles inserted (x_in toggling during gaps) -> one match; progress frozen during gaps; y_out low during gaps.
5. CNT_W=2, five non-overlapping matches -> match_count 1,2,3,3,3; then clear=1 together with x_valid=1 -> match_count=0, progress=0, y_out=0, bit ignored.
6. Feed 1,0,1, assert reset asynchronously mid-cycle -> outputs 0 before the next edge; release, feed 1 -> progress=1, no y_out.
